// File: rtl/ex_muldiv_pkg.sv
// Shared RV32M decode constants and multiply/divide FSM state encoding.
package ex_muldiv_pkg;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] INST_FUNC7_M  = 7'b0000001;

    localparam logic [2:0] INST_MUL    = 3'd0;
    localparam logic [2:0] INST_MULH   = 3'd1;
    localparam logic [2:0] INST_MULHSU = 3'd2;
    localparam logic [2:0] INST_MULHU  = 3'd3;
    localparam logic [2:0] INST_DIV    = 3'd4;
    localparam logic [2:0] INST_DIVU   = 3'd5;
    localparam logic [2:0] INST_REM    = 3'd6;
    localparam logic [2:0] INST_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_md_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes; exposes the final-step result combinationally.
module md_div_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic [XLEN-1:0]  dividend_i,
    input  logic [XLEN-1:0]  divisor_i,
    output logic             last_o,
    output logic [XLEN-1:0]  quotient_o,
    output logic [XLEN-1:0]  remainder_o
);

    logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [XLEN:0]    rem_sh, diff;
    logic [XLEN-1:0]  rem_step, quo_step;

    always_comb begin
        // Remainder is one bit wider while shifting so large unsigned divisors compare correctly.
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        diff     = rem_sh - {1'b0, dsr_q};
        quo_step = {quo_q[XLEN-2:0], ~diff[XLEN]};
        rem_step = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];

        rem_d = rem_q;
        quo_d = quo_q;
        dsr_d = dsr_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (flush_i) begin
            run_d = 1'b0;
        end else if (start_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dsr_d = divisor_i;
            cnt_d = CNT_W'(XLEN - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dsr_q <= dsr_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign last_o      = run_q && (cnt_q == '0);
    assign quotient_o  = quo_step;
    assign remainder_o = rem_step;

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: fixed-latency multiply, iterative divide, one write-back per op.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wen_o,
    output logic            busy_o,
    output logic            hold_flag_o
);

    md_state_e         state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d, result_q, result_d;
    logic [4:0]        rd_addr_q, rd_addr_d;

    logic              in_signed, div_zero, div_ovf, launch, div_start;
    logic [XLEN-1:0]   special_res, dvd_mag, dsr_mag, q_fix, r_fix;
    logic [2*XLEN-1:0] mul_a, mul_b, product;
    logic              div_last;
    logic [XLEN-1:0]   core_quo, core_rem;

    always_comb begin
        in_signed   = (op_i == INST_DIV) || (op_i == INST_REM);
        div_zero    = (op2_i == '0);
        div_ovf     = in_signed && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
        special_res = div_zero ? (op_i[1] ? op1_i : '1) : (op_i[1] ? '0 : op1_i);
        launch      = (state_q == ST_IDLE) && start_i && !flush_i;
        div_start   = launch && op_i[2] && !div_zero && !div_ovf;
        dvd_mag     = (in_signed && op1_i[XLEN-1]) ? -op1_i : op1_i;
        dsr_mag     = (in_signed && op2_i[XLEN-1]) ? -op2_i : op2_i;

        mul_a   = {{XLEN{op1_q[XLEN-1] && (op_q == INST_MULH || op_q == INST_MULHSU)}}, op1_q};
        mul_b   = {{XLEN{op2_q[XLEN-1] && (op_q == INST_MULH)}}, op2_q};
        product = mul_a * mul_b;

        q_fix = ((op_q == INST_DIV) && (op1_q[XLEN-1] ^ op2_q[XLEN-1])) ? -core_quo : core_quo;
        r_fix = ((op_q == INST_REM) && op1_q[XLEN-1]) ? -core_rem : core_rem;
    end

    md_div_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_div (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .start_i     (div_start),
        .dividend_i  (dvd_mag),
        .divisor_i   (dsr_mag),
        .last_o      (div_last),
        .quotient_o  (core_quo),
        .remainder_o (core_rem)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        rd_addr_d = rd_addr_q;
        result_d  = result_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) begin
                    op_d      = op_i;
                    op1_d     = op1_i;
                    op2_d     = op2_i;
                    rd_addr_d = rd_addr_i;
                    if (!op_i[2]) begin
                        state_d = ST_MUL;
                    end else if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
                ST_MUL: begin
                    result_d = (op_q == INST_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
                    state_d  = ST_DONE;
                end
                ST_DIV: if (div_last) begin
                    result_d = op_q[1] ? r_fix : q_fix;
                    state_d  = ST_DONE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            rd_addr_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            rd_addr_q <= rd_addr_d;
            result_q  <= result_d;
        end
    end

    assign rd_wen_o    = (state_q == ST_DONE) && (rd_addr_q != '0) && !flush_i;
    assign rd_data_o   = rd_wen_o ? result_q : '0;
    assign rd_addr_o   = rd_wen_o ? rd_addr_q : '0;
    assign busy_o      = (state_q != ST_IDLE);
    assign hold_flag_o = launch || (state_q == ST_MUL) || (state_q == ST_DIV);

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected write-backs, a monitor pops and compares.
module tb_ex_muldiv;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] op1_i, op2_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic [XLEN-1:0] rd_data_o;
    logic [4:0]      rd_addr_o;
    logic            rd_wen_o, busy_o, hold_flag_o;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .rd_addr_i   (rd_addr_i),
        .flush_i     (flush_i),
        .rd_data_o   (rd_data_o),
        .rd_addr_o   (rd_addr_o),
        .rd_wen_o    (rd_wen_o),
        .busy_o      (busy_o),
        .hold_flag_o (hold_flag_o)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        int          due;
    } exp_t;

    exp_t  expq[$];
    string nmq[$];
    int    checks = 0;
    int    passes = 0;
    int    cyc = 0;
    logic  hold_s, busy_s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (rd_wen_o === 1'b1) begin
            if (expq.size() == 0) begin
                chk("spurious_wen", 32'(rd_wen_o), 32'd0);
            end else begin
                exp_t  e;
                string n;
                e = expq.pop_front();
                n = nmq.pop_front();
                chk({n, "_data"}, rd_data_o, e.data);
                chk({n, "_addr"}, 32'(rd_addr_o), 32'(e.addr));
                chk({n, "_latency"}, cyc, e.due);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the start edge.
    task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                         input int lat, input bit wb);
        start_i   = 1'b1;
        op_i      = op;
        op1_i     = a;
        op2_i     = b;
        rd_addr_i = rd;
        if (wb) begin
            expq.push_back('{data: res, addr: rd, due: cyc + lat});
            nmq.push_back(nm);
        end
        #1;
        hold_s = hold_flag_o;
        busy_s = busy_o;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; op_i = '0; op1_i = '0; op2_i = '0;
        rd_addr_i = '0; flush_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_wen", 32'(rd_wen_o), 32'd0);
        chk("reset_data", rd_data_o, 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_hold", 32'(hold_flag_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 2, 1'b1);
        chk("mul_hold_start", 32'(hold_s), 32'd1);
        chk("mul_busy_start", 32'(busy_s), 32'd0);
        chk("mul_hold_mul", 32'(hold_flag_o), 32'd1);
        chk("mul_busy_mul", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("mul_hold_done", 32'(hold_flag_o), 32'd0);
        @(negedge clk);
        chk("mul_busy_idle", 32'(busy_o), 32'd0);

        issue("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 2, 1'b1);
        repeat (2) @(negedge clk);
        issue("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 2, 1'b1);
        repeat (2) @(negedge clk);
        issue("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 2, 1'b1);
        repeat (2) @(negedge clk);

        issue("div", 3'd4, 32'hFFFF_FFEC, 32'd3, 5'd5, 32'hFFFF_FFFA, 33, 1'b1);
        chk("div_busy_early", 32'(busy_o), 32'd1);
        repeat (20) @(negedge clk);
        chk("div_busy_mid", 32'(busy_o), 32'd1);
        chk("div_hold_mid", 32'(hold_flag_o), 32'd1);
        repeat (13) @(negedge clk);
        chk("div_busy_after", 32'(busy_o), 32'd0);
        issue("rem", 3'd6, 32'hFFFF_FFEC, 32'd3, 5'd6, 32'hFFFF_FFFE, 33, 1'b1);
        repeat (33) @(negedge clk);
        issue("divu", 3'd5, 32'd9, 32'd2, 5'd13, 32'd4, 33, 1'b1);
        repeat (33) @(negedge clk);
        issue("remu", 3'd7, 32'd9, 32'd2, 5'd14, 32'd1, 33, 1'b1);
        repeat (33) @(negedge clk);

        issue("divu_by0", 3'd5, 32'd100, 32'd0, 5'd7, 32'hFFFF_FFFF, 1, 1'b1);
        @(negedge clk);
        issue("rem_by0", 3'd6, 32'h1234, 32'd0, 5'd8, 32'h1234, 1, 1'b1);
        @(negedge clk);
        issue("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1, 1'b1);
        @(negedge clk);
        issue("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0, 1, 1'b1);
        @(negedge clk);

        issue("div_flushed", 3'd4, 32'd1000, 32'd7, 5'd11, 32'd0, 33, 1'b0);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_hold", 32'(hold_flag_o), 32'd0);
        issue("mul_after_flush", 3'd0, 32'd6, 32'd7, 5'd12, 32'd42, 2, 1'b1);
        repeat (2) @(negedge clk);

        issue("div_reset", 3'd4, 32'd1000, 32'd7, 5'd15, 32'd0, 33, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_wen", 32'(rd_wen_o), 32'd0);
        chk("arst_data", rd_data_o, 32'd0);
        chk("arst_addr", 32'(rd_addr_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_hold", 32'(hold_flag_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue("divu_rd0", 3'd5, 32'd9, 32'd2, 5'd0, 32'd0, 33, 1'b0);
        repeat (32) @(negedge clk);
        chk("rd0_busy_done", 32'(busy_o), 32'd1);
        chk("rd0_hold_done", 32'(hold_flag_o), 32'd0);
        chk("rd0_wen", 32'(rd_wen_o), 32'd0);
        chk("rd0_data", rd_data_o, 32'd0);
        @(negedge clk);
        chk("rd0_busy_idle", 32'(busy_o), 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
